// File: rtl/pit_ctrl_unit_pkg.sv
// Shared types for the 8254-style timer control unit:
// control-word layout, command codes, status bit positions.
package pit_pkg;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_WORD  = 2'b11
  } rw_e;

  typedef enum logic [2:0] {
    M_INTR     = 3'd0,
    M_ONESHOT  = 3'd1,
    M_RATE     = 3'd2,
    M_SQUARE   = 3'd3,
    M_SWSTB    = 3'd4,
    M_HWSTB    = 3'd5,
    M_RATE_X   = 3'd6,
    M_SQUARE_X = 3'd7
  } mode_e;

  typedef struct packed {
    rw_e   rw;
    mode_e m;
    logic  bcd;
  } ctrl_t;

  localparam logic [1:0] SC_READBACK = 2'b11;

  localparam ctrl_t CTRL_RST = '{
    rw: RW_WORD, m: M_INTR, bcd: 1'b0
  };

  localparam int ST_OUT  = 7;
  localparam int ST_NULL = 6;

  function automatic logic [7:0] mkStatus(
    input logic  outPin,
    input logic  nullCnt,
    input ctrl_t ctrl
  );
    logic [7:0] s;
    s = {2'b00, ctrl};
    s[ST_OUT]  = outPin;
    s[ST_NULL] = nullCnt;
    return s;
  endfunction

endpackage

// File: rtl/pit_ctrl_unit_if.sv
// Bus-side port bundle of the timer control unit.
// Write strobes, data and counter select in; read-side status out.
interface pit_bus_if #(
  parameter int NUM_BANKS = 1
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [7:0]    DIN;
  logic [BW-1:0] BANK;
  logic          CTRL_WR;
  logic          CNT_WR;
  logic          CNT_RD;
  logic [1:0]    CNT_SEL;
  logic          RD_STATUS;
  logic          RD_MSB;
  logic [7:0]    STATUS_BYTE;

  modport master (
    output DIN, BANK, CTRL_WR, CNT_WR, CNT_RD, CNT_SEL,
    input  RD_STATUS, RD_MSB, STATUS_BYTE
  );

  modport slave (
    input  DIN, BANK, CTRL_WR, CNT_WR, CNT_RD, CNT_SEL,
    output RD_STATUS, RD_MSB, STATUS_BYTE
  );
endinterface

// File: rtl/pit_ctrl_unit_chan_ctrl.sv
// Per-counter control state: mode word, byte pointers, latch/status
// pending, captured status and null-count. Inputs are decoded commands.
module pit_chan_ctrl
  import pit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       prog,
  input  ctrl_t      newCtrl,
  input  logic       latchCmd,
  input  logic       statCmd,
  input  logic       wr,
  input  logic       rd,
  input  logic       outPin,
  input  logic       loaded,
  output ctrl_t      ctrl,
  output logic       chgPulse,
  output logic       latchPulse,
  output logic       latched,
  output logic       wrMsb,
  output logic       rdMsb,
  output logic       statPend,
  output logic [7:0] statusQ
);

  logic nullQ;
  logic isWord;
  logic newMsb;

  assign isWord = (ctrl.rw == RW_WORD);
  assign newMsb = (newCtrl.rw == RW_MSB);

  // Statement order matters: the bus read is applied first,
  // a same-cycle program write then overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl       <= CTRL_RST;
      chgPulse   <= 1'b0;
      latchPulse <= 1'b0;
      latched    <= 1'b0;
      wrMsb      <= 1'b0;
      rdMsb      <= 1'b0;
      statPend   <= 1'b0;
      statusQ    <= 8'h00;
      nullQ      <= 1'b1;
    end else begin
      chgPulse   <= prog;
      latchPulse <= latchCmd && !latched;
      if (loaded)
        nullQ <= 1'b0;
      if (wr && isWord)
        wrMsb <= !wrMsb;
      if (rd) begin
        if (statPend) begin
          statPend <= 1'b0;
        end else begin
          if (isWord)
            rdMsb <= !rdMsb;
          if (!isWord || rdMsb)
            latched <= 1'b0;
        end
      end
      if (latchCmd && !latched)
        latched <= 1'b1;
      if (statCmd && !statPend) begin
        statusQ  <= mkStatus(outPin, nullQ, ctrl);
        statPend <= 1'b1;
      end
      if (prog) begin
        ctrl     <= newCtrl;
        nullQ    <= 1'b1;
        wrMsb    <= newMsb;
        rdMsb    <= newMsb;
        latched  <= 1'b0;
        statPend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pit_ctrl_unit.sv
// Control-word unit for a multi-bank 8254-style timer: decodes
// bus writes into per-counter commands, muxes the selected read state.
module pit_ctrl_unit
  import pit_pkg::*;
#(
  parameter int NUM_BANKS   = 1,
  parameter bit READBACK_EN = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  pit_bus_if.slave               bus,
  input  logic [3*NUM_BANKS-1:0] OUT_PIN,
  input  logic [3*NUM_BANKS-1:0] CNT_LOADED,
  output logic [18*NUM_BANKS-1:0] CTRL_WORD,
  output logic [3*NUM_BANKS-1:0] CHG_CTRL,
  output logic [3*NUM_BANKS-1:0] CNT_LATCH,
  output logic [3*NUM_BANKS-1:0] CNT_LATCHED,
  output logic [3*NUM_BANKS-1:0] WR_MSB
);

  localparam int N  = 3 * NUM_BANKS;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);

  logic       bankOk;
  logic [1:0] sc;
  logic       isRb;
  logic       rbOk;
  logic       isLatch;
  ctrl_t      newCtrl;
  logic       rsvdUnused;

  logic [N-1:0] prog, latchCmd, statCmd;
  logic [N-1:0] wr, rd, hit;
  logic [N-1:0] rdMsbV, statPendV;
  ctrl_t        ctrlV   [N];
  logic [7:0]   statusV [N];

  assign bankOk     = ({1'b0, bus.BANK} < NB);
  assign sc         = bus.DIN[7:6];
  assign isRb       = (sc == SC_READBACK);
  assign rbOk       = isRb && READBACK_EN;
  assign isLatch    = (bus.DIN[5:4] == RW_LATCH);
  assign newCtrl    = ctrl_t'(bus.DIN[5:0]);
  assign rsvdUnused = bus.DIN[0];

  for (genvar j = 0; j < N; j++) begin : g_chan
    localparam int B = j / 3;
    localparam int I = j % 3;
    logic bankHit, ctrlHit, scHit, rbSel;

    assign bankHit = bankOk && (bus.BANK == BW'(B));
    assign ctrlHit = bus.CTRL_WR && bankHit;
    assign scHit   = !isRb && (sc == 2'(I));
    assign rbSel   = rbOk && bus.DIN[I+1];
    assign hit[j]  = bankHit && (bus.CNT_SEL == 2'(I));

    assign prog[j]     = ctrlHit && scHit && !isLatch;
    assign latchCmd[j] = ctrlHit &&
      ((scHit && isLatch) || (rbSel && !bus.DIN[5]));
    assign statCmd[j]  = ctrlHit && rbSel && !bus.DIN[4];
    // A control write takes the cycle; a coincident count byte is lost.
    assign wr[j] = bus.CNT_WR && !bus.CTRL_WR && hit[j];
    assign rd[j] = bus.CNT_RD && hit[j];

    pit_chan_ctrl u_chan (
      .clk        (CLK),
      .rst        (RST),
      .prog       (prog[j]),
      .newCtrl    (newCtrl),
      .latchCmd   (latchCmd[j]),
      .statCmd    (statCmd[j]),
      .wr         (wr[j]),
      .rd         (rd[j]),
      .outPin     (OUT_PIN[j]),
      .loaded     (CNT_LOADED[j]),
      .ctrl       (ctrlV[j]),
      .chgPulse   (CHG_CTRL[j]),
      .latchPulse (CNT_LATCH[j]),
      .latched    (CNT_LATCHED[j]),
      .wrMsb      (WR_MSB[j]),
      .rdMsb      (rdMsbV[j]),
      .statPend   (statPendV[j]),
      .statusQ    (statusV[j])
    );

    assign CTRL_WORD[6*j +: 6] = ctrlV[j];
  end

  always_comb begin
    bus.RD_STATUS   = 1'b0;
    bus.RD_MSB      = 1'b0;
    bus.STATUS_BYTE = 8'h00;
    for (int j = 0; j < N; j++) begin
      if (hit[j]) begin
        bus.RD_STATUS   = statPendV[j];
        bus.RD_MSB      = rdMsbV[j];
        bus.STATUS_BYTE = statusV[j];
      end
    end
  end

endmodule
